// File: rtl/wt_mem_arb_pkg.sv
// Shared types and helpers for the write-through memory port arbiter.
//   - port_width(): width of the port tag carried in the memory ID
//   - arb_state_e : drain sequencing states
//   - mem_req_t   : one registered memory request {addr, wdata, we, id}
// The struct is sized by the package default widths; the arbiter's width
// parameters default to the same values.
package wt_mem_arb_pkg;

    // A single requester still needs one tag bit so the ID layout is fixed.
    function automatic int unsigned port_width(input int unsigned nr_ports);
        return (nr_ports <= 1) ? 1 : $clog2(nr_ports);
    endfunction

    localparam int unsigned NrPortsDef        = 2;
    localparam int unsigned AddrWidthDef      = 64;
    localparam int unsigned DataWidthDef      = 64;
    localparam int unsigned TidWidthDef       = 2;
    localparam int unsigned MaxOutstandingDef = 7;
    localparam int unsigned PortWidthDef      = port_width(NrPortsDef);
    localparam int unsigned MemIdWidthDef     = PortWidthDef + TidWidthDef;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        DRAINED = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [AddrWidthDef-1:0]  addr;
        logic [DataWidthDef-1:0]  wdata;
        logic                     we;
        logic [MemIdWidthDef-1:0] id;
    } mem_req_t;

endpackage

// File: rtl/wt_mem_port_arbiter_if.sv
// Bundle of all cache-side, memory-side and drain signals of the arbiter.
//   slave  : arbiter view (requests/responses in from memory, grants out)
//   master : environment view (caches, memory adapter, fence logic)
// Handshakes: a cache request transfers in a cycle where req_valid_i[p] and
// req_ready_o[p] are both high; a memory request transfers in a cycle where
// mem_valid_o and mem_ready_i are both high, and mem_* stays stable until
// then; responses (mem_rvalid_i) cannot be back-pressured.
interface wt_mem_port_arbiter_if import wt_mem_arb_pkg::*; #(
    parameter int unsigned NrPorts        = NrPortsDef,
    parameter int unsigned AddrWidth      = AddrWidthDef,
    parameter int unsigned DataWidth      = DataWidthDef,
    parameter int unsigned TidWidth       = TidWidthDef,
    parameter int unsigned MaxOutstanding = MaxOutstandingDef
) ();
    localparam int unsigned PortWidth = port_width(NrPorts);
    localparam int unsigned IdWidth   = PortWidth + TidWidth;
    localparam int unsigned CntWidth  = $clog2(MaxOutstanding + 1);

    logic [NrPorts-1:0]           req_valid_i;
    logic [NrPorts-1:0]           req_ready_o;
    logic [NrPorts*AddrWidth-1:0] req_addr_i;
    logic [NrPorts*DataWidth-1:0] req_wdata_i;
    logic [NrPorts-1:0]           req_we_i;
    logic [NrPorts*TidWidth-1:0]  req_tid_i;
    logic                         mem_valid_o;
    logic                         mem_ready_i;
    logic [AddrWidth-1:0]         mem_addr_o;
    logic [DataWidth-1:0]         mem_wdata_o;
    logic                         mem_we_o;
    logic [IdWidth-1:0]           mem_id_o;
    logic                         mem_rvalid_i;
    logic [IdWidth-1:0]           mem_rid_i;
    logic [DataWidth-1:0]         mem_rdata_i;
    logic [NrPorts-1:0]           rsp_valid_o;
    logic [NrPorts*TidWidth-1:0]  rsp_tid_o;
    logic [DataWidth-1:0]         rsp_rdata_o;
    logic                         drain_req_i;
    logic                         drain_done_o;
    logic [CntWidth-1:0]          outstanding_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_wdata_i, req_we_i, req_tid_i,
        input  mem_ready_i, mem_rvalid_i, mem_rid_i, mem_rdata_i, drain_req_i,
        output req_ready_o, mem_valid_o, mem_addr_o, mem_wdata_o, mem_we_o,
        output mem_id_o, rsp_valid_o, rsp_tid_o, rsp_rdata_o, drain_done_o,
        output outstanding_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_wdata_i, req_we_i, req_tid_i,
        output mem_ready_i, mem_rvalid_i, mem_rid_i, mem_rdata_i, drain_req_i,
        input  req_ready_o, mem_valid_o, mem_addr_o, mem_wdata_o, mem_we_o,
        input  mem_id_o, rsp_valid_o, rsp_tid_o, rsp_rdata_o, drain_done_o,
        input  outstanding_o
    );
endinterface

// File: rtl/wt_mem_rr_pick.sv
// Combinational round-robin pick.
//   valid_i : request vector
//   ptr_i   : highest-priority index this cycle
//   gnt_o   : one-hot pick (zero when nothing is valid)
//   idx_o   : index of the pick
//   any_o   : at least one request is valid
module wt_mem_rr_pick #(
    parameter int unsigned NrPorts   = 2,
    parameter int unsigned PortWidth = 1
) (
    input  logic [NrPorts-1:0]   valid_i,
    input  logic [PortWidth-1:0] ptr_i,
    output logic [NrPorts-1:0]   gnt_o,
    output logic [PortWidth-1:0] idx_o,
    output logic                 any_o
);
    logic [PortWidth-1:0] cand;

    // Scan from the pointer upwards, wrapping; the first valid port wins.
    always_comb begin : p_pick
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < NrPorts; i++) begin
            cand = PortWidth'((32'(ptr_i) + i) % NrPorts);
            if (!any_o && valid_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end
endmodule

// File: rtl/wt_mem_port_arbiter.sv
// Shares the write-through memory port between the I-cache (port 0) and the
// write-through D-cache (port 1). Round-robin grant into a one-entry output
// register, port tag prepended to the requester tid to form the memory ID,
// in-flight limit, response routing by ID and a drain handshake.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   bus           : request, memory, response and drain signals (slave view)
module wt_mem_port_arbiter import wt_mem_arb_pkg::*; #(
    parameter int unsigned NrPorts        = NrPortsDef,
    parameter int unsigned AddrWidth      = AddrWidthDef,
    parameter int unsigned DataWidth      = DataWidthDef,
    parameter int unsigned TidWidth       = TidWidthDef,
    parameter int unsigned MaxOutstanding = MaxOutstandingDef
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    wt_mem_port_arbiter_if.slave  bus
);
    localparam int unsigned PortWidth = port_width(NrPorts);
    localparam int unsigned IdWidth   = PortWidth + TidWidth;
    localparam int unsigned CntWidth  = $clog2(MaxOutstanding + 1);

    arb_state_e           state_q, state_d;
    mem_req_t             req_q, req_d;
    logic                 valid_q, valid_d;
    logic [PortWidth-1:0] ptr_q, ptr_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;

    logic [NrPorts-1:0]   pick_gnt;
    logic [PortWidth-1:0] pick_idx;
    logic                 pick_any;
    logic                 reg_free, grant_en, grant, rsp_dec, drain_done;
    logic [PortWidth-1:0] rid_port;
    logic [TidWidth-1:0]  rid_tid;

    wt_mem_rr_pick #(.NrPorts(NrPorts), .PortWidth(PortWidth)) u_pick (
        .valid_i (bus.req_valid_i),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // The entry being accepted by memory this cycle can be refilled at once.
    // The limit uses the registered count only, so a same-cycle response
    // does not open a grant at the limit.
    assign reg_free = !valid_q || bus.mem_ready_i;
    assign grant_en = (state_q == RUN) && !bus.drain_req_i && reg_free &&
                      (cnt_q < CntWidth'(MaxOutstanding));
    assign grant    = grant_en && pick_any;
    assign rsp_dec  = bus.mem_rvalid_i && (cnt_q != '0);

    assign bus.req_ready_o = grant_en ? pick_gnt : '0;

    always_comb begin : p_datapath
        req_d   = req_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (grant) begin
            valid_d     = 1'b1;
            req_d.addr  = bus.req_addr_i[pick_idx*AddrWidth +: AddrWidth];
            req_d.wdata = bus.req_wdata_i[pick_idx*DataWidth +: DataWidth];
            req_d.we    = bus.req_we_i[pick_idx];
            req_d.id    = {pick_idx, bus.req_tid_i[pick_idx*TidWidth +: TidWidth]};
            ptr_d       = (pick_idx == PortWidth'(NrPorts - 1)) ? '0 : pick_idx + 1'b1;
        end else if (valid_q && bus.mem_ready_i) begin
            valid_d = 1'b0;
        end
        case ({grant, rsp_dec})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin : p_regs
        if (!rst_ni) begin
            valid_q <= 1'b0;
            req_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            req_q   <= req_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin : p_state
        if (!rst_ni) state_q <= RUN;
        else         state_q <= state_d;
    end

    // DRAIN looks at the next count and occupancy so drain_done rises the
    // cycle after the last response instead of one cycle later.
    always_comb begin : p_fsm_next
        state_d = state_q;
        unique case (state_q)
            RUN:     if (bus.drain_req_i) state_d = DRAIN;
            DRAIN:   if (!bus.drain_req_i) state_d = RUN;
                     else if ((cnt_d == '0) && !valid_d) state_d = DRAINED;
            DRAINED: if (!bus.drain_req_i) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin : p_fsm_out
        drain_done = (state_q == DRAINED);
    end

    assign bus.drain_done_o  = drain_done;
    assign bus.outstanding_o = cnt_q;
    assign bus.mem_valid_o   = valid_q;
    assign bus.mem_addr_o    = req_q.addr;
    assign bus.mem_wdata_o   = req_q.wdata;
    assign bus.mem_we_o      = req_q.we;
    assign bus.mem_id_o      = req_q.id;

    // Responses pass straight through; an out-of-range port tag matches no port.
    assign rid_port        = bus.mem_rid_i[IdWidth-1 -: PortWidth];
    assign rid_tid         = bus.mem_rid_i[TidWidth-1:0];
    assign bus.rsp_rdata_o = bus.mem_rdata_i;

    for (genvar p = 0; p < NrPorts; p++) begin : g_rsp
        assign bus.rsp_valid_o[p]                     = bus.mem_rvalid_i && (rid_port == PortWidth'(p));
        assign bus.rsp_tid_o[p*TidWidth +: TidWidth]  = rid_tid;
    end

    a_rsp_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.mem_rvalid_i |-> (cnt_q != '0));

    if ((1 << PortWidth) != NrPorts) begin : g_port_chk
        a_rid_port_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
            bus.mem_rvalid_i |-> (32'(rid_port) < NrPorts));
    end
endmodule

// File: tb/tb_wt_mem_port_arbiter.sv
module tb_wt_mem_port_arbiter;
    import wt_mem_arb_pkg::*;

    localparam int NP = 2;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int TW = 2;
    localparam int MO = 7;
    localparam int IW = 3;
    localparam int W  = AW + DW + 1 + IW;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wt_mem_port_arbiter_if #(.NrPorts(NP), .AddrWidth(AW), .DataWidth(DW),
                             .TidWidth(TW), .MaxOutstanding(MO)) bus ();

    wt_mem_port_arbiter #(.NrPorts(NP), .AddrWidth(AW), .DataWidth(DW),
                          .TidWidth(TW), .MaxOutstanding(MO)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req_valid_i  = '0;
        bus.req_addr_i   = '0;
        bus.req_wdata_i  = '0;
        bus.req_we_i     = '0;
        bus.req_tid_i    = '0;
        bus.mem_ready_i  = 1'b1;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rid_i    = '0;
        bus.mem_rdata_i  = '0;
        bus.drain_req_i  = 1'b0;
    endtask

    task automatic set_req(input int p, input bit v, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input bit we, input logic [TW-1:0] tid);
        bus.req_valid_i[p]           = v;
        bus.req_addr_i[p*AW +: AW]   = a;
        bus.req_wdata_i[p*DW +: DW]  = d;
        bus.req_we_i[p]              = we;
        bus.req_tid_i[p*TW +: TW]    = tid;
    endtask

    task automatic rand_req(input int p, input bit v);
        set_req(p, v, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                TW'($urandom_range(0, 3)));
    endtask

    task automatic respond(input bit v, input logic [IW-1:0] rid, input logic [DW-1:0] d);
        bus.mem_rvalid_i = v;
        bus.mem_rid_i    = rid;
        bus.mem_rdata_i  = d;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- reference model + scoreboard ----------------
    logic [0:0] m_ptr   = '0;
    int         m_cnt   = 0;
    bit         m_occ   = 1'b0;
    int         m_state = 0;  // 0 run, 1 drain, 2 drained

    always @(negedge clk) begin : model
        logic [NP-1:0] exp_rdy;
        logic [NP-1:0] exp_rv;
        bit            gen;
        int            g;
        int            p;
        int            cnt_n;
        bit            occ_n;
        if (!rst_n) begin
            m_ptr   = '0;
            m_cnt   = 0;
            m_occ   = 1'b0;
            m_state = 0;
            exp_q.delete();
        end else begin
            check("m_mem_valid", bus.mem_valid_o, m_occ);
            check("m_outstanding", bus.outstanding_o, m_cnt);
            check("m_drain_done", bus.drain_done_o, m_state == 2);
            gen = (m_state == 0) && !bus.drain_req_i && (!m_occ || bus.mem_ready_i) && (m_cnt < MO);
            g = -1;
            if (gen) begin
                for (int k = 0; k < NP; k++) begin
                    p = (m_ptr + k) % NP;
                    if (g < 0 && bus.req_valid_i[p]) g = p;
                end
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            check("m_req_ready", bus.req_ready_o, exp_rdy);
            if (m_occ && bus.mem_ready_i) begin
                if (exp_q.size() == 0) check("m_sb_underflow", 1, 0);
                else check("m_mem_req", {bus.mem_addr_o, bus.mem_wdata_o, bus.mem_we_o, bus.mem_id_o},
                           exp_q.pop_front());
            end
            exp_rv = '0;
            if (bus.mem_rvalid_i) exp_rv[bus.mem_rid_i[2]] = 1'b1;
            check("m_rsp_valid", bus.rsp_valid_o, exp_rv);
            if (bus.mem_rvalid_i) begin
                check("m_rsp_tid", bus.rsp_tid_o[bus.mem_rid_i[2]*TW +: TW], bus.mem_rid_i[1:0]);
                check("m_rsp_rdata", bus.rsp_rdata_o, bus.mem_rdata_i);
            end
            if (g >= 0) begin
                exp_q.push_back({bus.req_addr_i[g*AW +: AW], bus.req_wdata_i[g*DW +: DW],
                                 bus.req_we_i[g], 1'(g), bus.req_tid_i[g*TW +: TW]});
                m_ptr = 1'((g + 1) % NP);
            end
            occ_n = (g >= 0) ? 1'b1 : ((m_occ && bus.mem_ready_i) ? 1'b0 : m_occ);
            cnt_n = m_cnt + ((g >= 0) ? 1 : 0) - ((bus.mem_rvalid_i && m_cnt > 0) ? 1 : 0);
            case (m_state)
                0: if (bus.drain_req_i) m_state = 1;
                1: if (!bus.drain_req_i) m_state = 0;
                   else if (cnt_n == 0 && !occ_n) m_state = 2;
                default: if (!bus.drain_req_i) m_state = 0;
            endcase
            m_cnt = cnt_n;
            m_occ = occ_n;
        end
    end

    // ---------------- directed sequence ----------------
    initial begin : stim
        int g0;
        int g1;
        int ng;
        logic [AW-1:0] a6;
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mem_valid", bus.mem_valid_o, 0);
        check("rst_mem_addr", bus.mem_addr_o, 0);
        check("rst_mem_wdata", bus.mem_wdata_o, 0);
        check("rst_mem_we", bus.mem_we_o, 0);
        check("rst_mem_id", bus.mem_id_o, 0);
        check("rst_outstanding", bus.outstanding_o, 0);
        check("rst_drain_done", bus.drain_done_o, 0);
        tick();

        // single port-0 request
        set_req(0, 1'b1, 64'h8000_0000, 64'h1234, 1'b0, 2'b01);
        @(negedge clk);
        check("t1_ready", bus.req_ready_o, 2'b01);
        tick();
        set_req(0, 1'b0, '0, '0, 1'b0, '0);
        respond(1'b1, 3'b001, 64'h55);
        @(negedge clk);
        check("t1_mem_valid", bus.mem_valid_o, 1);
        check("t1_mem_addr", bus.mem_addr_o, 64'h8000_0000);
        check("t1_mem_id", bus.mem_id_o, 3'b001);
        check("t1_rsp_valid", bus.rsp_valid_o, 2'b01);
        tick();
        respond(1'b0, '0, '0);

        // fairness: both ports always valid
        do_reset();
        g0 = 0;
        g1 = 0;
        for (int k = 0; k < 20; k++) begin
            rand_req(0, 1'b1);
            rand_req(1, 1'b1);
            respond(k >= 2, IW'($urandom_range(0, 7)), {$urandom, $urandom});
            @(negedge clk);
            check($sformatf("t2_gnt%0d", k), bus.req_ready_o, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (bus.req_ready_o == 2'b01) g0++;
            if (bus.req_ready_o == 2'b10) g1++;
            tick();
        end
        check("t2_port0_served", g0, 10);
        check("t2_port1_served", g1, 10);

        // in-flight limit
        do_reset();
        ng = 0;
        for (int k = 0; k < 10; k++) begin
            rand_req(0, 1'b1);
            rand_req(1, 1'b1);
            @(negedge clk);
            check($sformatf("t3_gnt%0d", k), bus.req_ready_o,
                  (k >= MO) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10));
            if (bus.req_ready_o != 0) ng++;
            tick();
        end
        check("t3_grants", ng, MO);
        check("t3_outstanding", bus.outstanding_o, MO);
        respond(1'b1, 3'b000, 64'h1);
        @(negedge clk);
        check("t3_limit_same_cycle", bus.req_ready_o, 2'b00);
        tick();
        respond(1'b0, '0, '0);
        @(negedge clk);
        check("t3_one_more", bus.req_ready_o, 2'b10);
        tick();
        respond(1'b1, 3'b100, 64'h2);
        @(negedge clk);
        check("t3_blocked_again", bus.req_ready_o, 2'b00);
        check("t3_full_again", bus.outstanding_o, MO);
        tick();
        @(negedge clk);
        check("t3_simul_gnt", bus.req_ready_o, 2'b01);
        check("t3_simul_cnt_before", bus.outstanding_o, MO - 1);
        tick();
        respond(1'b0, '0, '0);
        @(negedge clk);
        check("t3_simul_cnt_after", bus.outstanding_o, MO - 1);
        tick();

        // response routing
        set_req(0, 1'b0, '0, '0, 1'b0, '0);
        set_req(1, 1'b0, '0, '0, 1'b0, '0);
        respond(1'b1, 3'b110, 64'hDEAD);
        @(negedge clk);
        check("t4_rsp_valid", bus.rsp_valid_o, 2'b10);
        check("t4_rsp_tid1", bus.rsp_tid_o[3:2], 2'b10);
        check("t4_rsp_rdata", bus.rsp_rdata_o, 64'hDEAD);
        tick();
        respond(1'b0, '0, '0);

        // drain with three in flight
        do_reset();
        for (int k = 0; k < 3; k++) begin
            rand_req(0, 1'b1);
            tick();
        end
        set_req(0, 1'b0, '0, '0, 1'b0, '0);
        rand_req(1, 1'b1);
        bus.drain_req_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("t5_nogrant%0d", k), bus.req_ready_o, 2'b00);
            tick();
        end
        check("t5_outstanding", bus.outstanding_o, 3);
        for (int k = 0; k < 3; k++) begin
            respond(1'b1, {1'b0, 2'(k)}, 64'(k));
            @(negedge clk);
            check($sformatf("t5_not_done%0d", k), bus.drain_done_o, 0);
            tick();
        end
        respond(1'b0, '0, '0);
        @(negedge clk);
        check("t5_drain_done", bus.drain_done_o, 1);
        tick();
        bus.drain_req_i = 1'b0;
        @(negedge clk);
        check("t5_release_cycle", bus.req_ready_o, 2'b00);
        tick();
        @(negedge clk);
        check("t5_resume_gnt", bus.req_ready_o, 2'b10);
        tick();
        set_req(1, 1'b0, '0, '0, 1'b0, '0);

        // reset while the output register is stalled
        do_reset();
        bus.mem_ready_i = 1'b0;
        a6 = {$urandom, $urandom};
        set_req(0, 1'b1, a6, 64'h77, 1'b1, 2'b11);
        @(negedge clk);
        check("t6_gnt", bus.req_ready_o, 2'b01);
        tick();
        set_req(0, 1'b0, '0, '0, 1'b0, '0);
        rand_req(1, 1'b1);
        @(negedge clk);
        check("t6_not_free", bus.req_ready_o, 2'b00);
        check("t6_addr_held0", bus.mem_addr_o, a6);
        tick();
        set_req(1, 1'b0, '0, '0, 1'b0, '0);
        @(negedge clk);
        check("t6_addr_held1", bus.mem_addr_o, a6);
        check("t6_valid_held", bus.mem_valid_o, 1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_rst_valid", bus.mem_valid_o, 0);
        check("t6_rst_outstanding", bus.outstanding_o, 0);
        tick();
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
